// File: rtl/mic_trigger_ctrl.sv
// Run-control sequencer for the PDM mic chain: gates the chain, discards CIC
// settling samples after start, qualifies threshold crossings as events.
module mic_trigger_ctrl #(
  parameter int unsigned W_LVL = 16,
  parameter int unsigned W_CNT = 16,
  parameter int unsigned W_HIT = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_start_i,
  input  logic             cmd_stop_i,
  input  logic             clr_event_i,
  input  logic [W_CNT-1:0] cfg_warmup_i,
  input  logic [W_HIT-1:0] cfg_hold_i,
  input  logic [W_CNT-1:0] cfg_holdoff_i,
  input  logic             pcm_valid_i,
  input  logic [W_LVL-1:0] level_i,
  input  logic             above_thresh_i,
  input  logic             level_ready_i,
  output logic             mic_en_o,
  output logic [1:0]       state_o,
  output logic             trig_pulse_o,
  output logic [W_CNT-1:0] trig_count_o,
  output logic [W_LVL-1:0] peak_level_o,
  output logic             event_sticky_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWarmup  = 2'd1,
    StArmed   = 2'd2,
    StHoldoff = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             mic_en_q, mic_en_d;
  logic             trig_pulse_q, trig_pulse_d;
  logic [W_CNT-1:0] trig_count_q, trig_count_d;
  logic [W_LVL-1:0] peak_q, peak_d;
  logic             sticky_q, sticky_d;
  logic [W_CNT-1:0] warm_cnt_q, warm_cnt_d;
  logic [W_HIT-1:0] hit_cnt_q, hit_cnt_d;
  logic [W_CNT-1:0] hold_cnt_q, hold_cnt_d;

  // One extra bit so hit_cnt+1 cannot wrap when compared against the hold limit.
  logic [W_HIT:0]   hit_next;
  logic [W_HIT:0]   hold_eff;

  assign hit_next = {1'b0, hit_cnt_q} + 1'b1;
  assign hold_eff = (cfg_hold_i == '0) ? {{W_HIT{1'b0}}, 1'b1} : {1'b0, cfg_hold_i};

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      mic_en_q     <= 1'b0;
      trig_pulse_q <= 1'b0;
      trig_count_q <= '0;
      peak_q       <= '0;
      sticky_q     <= 1'b0;
      warm_cnt_q   <= '0;
      hit_cnt_q    <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mic_en_q     <= mic_en_d;
      trig_pulse_q <= trig_pulse_d;
      trig_count_q <= trig_count_d;
      peak_q       <= peak_d;
      sticky_q     <= sticky_d;
      warm_cnt_q   <= warm_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Next-state logic: stop overrides everything, event set overrides clear.
  always_comb begin
    state_d      = state_q;
    trig_pulse_d = 1'b0;
    trig_count_d = trig_count_q;
    peak_d       = peak_q;
    sticky_d     = sticky_q;
    warm_cnt_d   = warm_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    hold_cnt_d   = hold_cnt_q;

    if (clr_event_i) begin
      sticky_d = 1'b0;
    end

    if (cmd_stop_i) begin
      state_d = StIdle;
    end else begin
      // Peak tracks every valid level while the detector output is being watched.
      if (level_ready_i && (state_q == StArmed || state_q == StHoldoff) && level_i > peak_q) begin
        peak_d = level_i;
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_start_i) begin
            state_d      = StWarmup;
            trig_count_d = '0;
            peak_d       = '0;
            warm_cnt_d   = '0;
            hit_cnt_d    = '0;
          end
        end
        StWarmup: begin
          if (cfg_warmup_i == '0) begin
            state_d = StArmed;
          end else if (pcm_valid_i) begin
            warm_cnt_d = warm_cnt_q + 1'b1;
            // >= so a limit lowered below the running count still ends warmup.
            if (warm_cnt_q >= cfg_warmup_i - 1'b1) begin
              state_d = StArmed;
            end
          end
        end
        StArmed: begin
          if (level_ready_i) begin
            if (!above_thresh_i) begin
              hit_cnt_d = '0;
            end else if (hit_next >= hold_eff) begin
              state_d      = StHoldoff;
              trig_pulse_d = 1'b1;
              sticky_d     = 1'b1;
              hit_cnt_d    = '0;
              hold_cnt_d   = cfg_holdoff_i;
              if (trig_count_q != '1) begin
                trig_count_d = trig_count_q + 1'b1;
              end
            end else begin
              hit_cnt_d = hit_cnt_q + 1'b1;
            end
          end
        end
        StHoldoff: begin
          hit_cnt_d = '0;
          if (hold_cnt_q == '0) begin
            state_d = StArmed;
          end else if (level_ready_i) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    mic_en_d = (state_d != StIdle);
  end

  assign mic_en_o       = mic_en_q;
  assign state_o        = state_q;
  assign trig_pulse_o   = trig_pulse_q;
  assign trig_count_o   = trig_count_q;
  assign peak_level_o   = peak_q;
  assign event_sticky_o = sticky_q;

endmodule

// File: tb/tb_mic_trigger_ctrl.sv
// Directed self-checking bench for mic_trigger_ctrl. A second instance with an
// 8-bit event counter exercises saturation within a short run.
module tb_mic_trigger_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_start_i, cmd_stop_i, clr_event_i;
  logic [15:0] cfg_warmup_i, cfg_holdoff_i;
  logic [7:0]  cfg_hold_i;
  logic        pcm_valid_i;
  logic [15:0] level_i;
  logic        above_thresh_i, level_ready_i;

  logic        mic_en_o, trig_pulse_o, event_sticky_o;
  logic [1:0]  state_o;
  logic [15:0] trig_count_o, peak_level_o;

  logic        s_mic_en, s_trig_pulse, s_sticky;
  logic [1:0]  s_state;
  logic [7:0]  s_trig_count;
  logic [15:0] s_peak;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mic_trigger_ctrl dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .cmd_start_i    (cmd_start_i),
    .cmd_stop_i     (cmd_stop_i),
    .clr_event_i    (clr_event_i),
    .cfg_warmup_i   (cfg_warmup_i),
    .cfg_hold_i     (cfg_hold_i),
    .cfg_holdoff_i  (cfg_holdoff_i),
    .pcm_valid_i    (pcm_valid_i),
    .level_i        (level_i),
    .above_thresh_i (above_thresh_i),
    .level_ready_i  (level_ready_i),
    .mic_en_o       (mic_en_o),
    .state_o        (state_o),
    .trig_pulse_o   (trig_pulse_o),
    .trig_count_o   (trig_count_o),
    .peak_level_o   (peak_level_o),
    .event_sticky_o (event_sticky_o)
  );

  mic_trigger_ctrl #(.W_LVL(16), .W_CNT(8), .W_HIT(8)) dut_s (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .cmd_start_i    (cmd_start_i),
    .cmd_stop_i     (cmd_stop_i),
    .clr_event_i    (clr_event_i),
    .cfg_warmup_i   (cfg_warmup_i[7:0]),
    .cfg_hold_i     (cfg_hold_i),
    .cfg_holdoff_i  (cfg_holdoff_i[7:0]),
    .pcm_valid_i    (pcm_valid_i),
    .level_i        (level_i),
    .above_thresh_i (above_thresh_i),
    .level_ready_i  (level_ready_i),
    .mic_en_o       (s_mic_en),
    .state_o        (s_state),
    .trig_pulse_o   (s_trig_pulse),
    .trig_count_o   (s_trig_count),
    .peak_level_o   (s_peak),
    .event_sticky_o (s_sticky)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic strobe(input logic above, input logic [15:0] lvl);
    level_ready_i  = 1'b1;
    above_thresh_i = above;
    level_i        = lvl;
    step();
    level_ready_i  = 1'b0;
    above_thresh_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++; if (mic_en_o !== 1'b0) begin errors++; $display("FAIL reset_mic_en got %b want 0", mic_en_o); end
    checks++; if (trig_count_o !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", trig_count_o); end
    checks++; if (peak_level_o !== 16'd0) begin errors++; $display("FAIL reset_peak got %0d want 0", peak_level_o); end
    checks++; if (event_sticky_o !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", event_sticky_o); end
  endtask

  task automatic test_warmup();
    cfg_warmup_i = 16'd4;
    cmd_start_i  = 1'b1;
    step();
    cmd_start_i  = 1'b0;
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL warmup_enter got %0d want 1", state_o); end
    for (int i = 0; i < 3; i++) begin
      pcm_valid_i = 1'b1;
      step();
      pcm_valid_i = 1'b0;
      strobe(1'b1, 16'd999); // ignored during warmup
    end
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL warmup_3pcm got %0d want 1", state_o); end
    checks++; if (mic_en_o !== 1'b1) begin errors++; $display("FAIL warmup_mic_en got %b want 1", mic_en_o); end
    checks++; if (peak_level_o !== 16'd0) begin errors++; $display("FAIL warmup_peak got %0d want 0", peak_level_o); end
    pcm_valid_i = 1'b1;
    step();
    pcm_valid_i = 1'b0;
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL warmup_armed got %0d want 2", state_o); end
    checks++; if (mic_en_o !== 1'b1) begin errors++; $display("FAIL armed_mic_en got %b want 1", mic_en_o); end
  endtask

  task automatic test_qualify();
    logic        ab [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] lv [6] = '{16'd10, 16'd20, 16'd5, 16'd30, 16'd40, 16'd25};
    cfg_hold_i    = 8'd3;
    cfg_holdoff_i = 16'd2;
    for (int i = 0; i < 6; i++) begin
      strobe(ab[i], lv[i]);
      if (i < 5) begin
        checks++; if (trig_pulse_o !== 1'b0) begin errors++; $display("FAIL early_pulse idx %0d got %b want 0", i, trig_pulse_o); end
      end
    end
    checks++; if (trig_pulse_o !== 1'b1) begin errors++; $display("FAIL trig_pulse got %b want 1", trig_pulse_o); end
    checks++; if (trig_count_o !== 16'd1) begin errors++; $display("FAIL trig_count got %0d want 1", trig_count_o); end
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL holdoff_state got %0d want 3", state_o); end
    checks++; if (peak_level_o !== 16'd40) begin errors++; $display("FAIL peak got %0d want 40", peak_level_o); end
    checks++; if (event_sticky_o !== 1'b1) begin errors++; $display("FAIL sticky_set got %b want 1", event_sticky_o); end
    strobe(1'b1, 16'd50);
    checks++; if (trig_pulse_o !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", trig_pulse_o); end
    strobe(1'b1, 16'd7);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL holdoff_2strobes got %0d want 3", state_o); end
    step();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL holdoff_exit got %0d want 2", state_o); end
    checks++; if (peak_level_o !== 16'd50) begin errors++; $display("FAIL peak_holdoff got %0d want 50", peak_level_o); end
    checks++; if (trig_count_o !== 16'd1) begin errors++; $display("FAIL count_after_holdoff got %0d want 1", trig_count_o); end
  endtask

  task automatic test_simultaneous();
    clr_event_i = 1'b1;
    step();
    clr_event_i = 1'b0;
    checks++; if (event_sticky_o !== 1'b0) begin errors++; $display("FAIL clr_alone got %b want 0", event_sticky_o); end
    // hold=0 behaves as 1: a single above strobe fires, with clear in the same cycle.
    cfg_hold_i    = 8'd0;
    cfg_holdoff_i = 16'd0;
    clr_event_i   = 1'b1;
    strobe(1'b1, 16'd3);
    clr_event_i   = 1'b0;
    checks++; if (event_sticky_o !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b want 1", event_sticky_o); end
    checks++; if (trig_count_o !== 16'd2) begin errors++; $display("FAIL hold0_count got %0d want 2", trig_count_o); end
    step();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL holdoff0_exit got %0d want 2", state_o); end
    // Fire again, then stop while in HOLDOFF.
    cfg_holdoff_i = 16'd5;
    strobe(1'b1, 16'd4);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL refire_state got %0d want 3", state_o); end
    cmd_stop_i = 1'b1;
    step();
    cmd_stop_i = 1'b0;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL stop_state got %0d want 0", state_o); end
    checks++; if (mic_en_o !== 1'b0) begin errors++; $display("FAIL stop_mic_en got %b want 0", mic_en_o); end
    checks++; if (trig_count_o !== 16'd3) begin errors++; $display("FAIL stop_count got %0d want 3", trig_count_o); end
    checks++; if (peak_level_o !== 16'd50) begin errors++; $display("FAIL stop_peak got %0d want 50", peak_level_o); end
    checks++; if (event_sticky_o !== 1'b1) begin errors++; $display("FAIL stop_sticky got %b want 1", event_sticky_o); end
    cmd_start_i = 1'b1;
    cmd_stop_i  = 1'b1;
    step();
    cmd_start_i = 1'b0;
    cmd_stop_i  = 1'b0;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL start_stop got %0d want 0", state_o); end
    checks++; if (trig_count_o !== 16'd3) begin errors++; $display("FAIL start_stop_count got %0d want 3", trig_count_o); end
  endtask

  task automatic test_restart_and_reset();
    cfg_warmup_i  = 16'd0;
    cfg_holdoff_i = 16'd0;
    cmd_start_i   = 1'b1;
    step();
    cmd_start_i   = 1'b0;
    checks++; if (trig_count_o !== 16'd0) begin errors++; $display("FAIL start_clears_count got %0d want 0", trig_count_o); end
    checks++; if (peak_level_o !== 16'd0) begin errors++; $display("FAIL start_clears_peak got %0d want 0", peak_level_o); end
    checks++; if (event_sticky_o !== 1'b1) begin errors++; $display("FAIL start_keeps_sticky got %b want 1", event_sticky_o); end
    step();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL warmup0 got %0d want 2", state_o); end
    strobe(1'b1, 16'd77);
    step();
    cmd_start_i = 1'b1;
    step();
    cmd_start_i = 1'b0;
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL start_ignored got %0d want 2", state_o); end
    checks++; if (trig_count_o !== 16'd1) begin errors++; $display("FAIL start_ignored_count got %0d want 1", trig_count_o); end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL midreset_state got %0d want 0", state_o); end
    checks++; if (mic_en_o !== 1'b0) begin errors++; $display("FAIL midreset_mic_en got %b want 0", mic_en_o); end
    checks++; if (trig_count_o !== 16'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", trig_count_o); end
    checks++; if (peak_level_o !== 16'd0) begin errors++; $display("FAIL midreset_peak got %0d want 0", peak_level_o); end
    checks++; if (event_sticky_o !== 1'b0) begin errors++; $display("FAIL midreset_sticky got %b want 0", event_sticky_o); end
  endtask

  task automatic test_saturation();
    cfg_warmup_i  = 16'd0;
    cfg_hold_i    = 8'd0;
    cfg_holdoff_i = 16'd0;
    cmd_start_i   = 1'b1;
    step();
    cmd_start_i   = 1'b0;
    step();
    // Strobe every cycle: events land on alternate cycles (ARMED, HOLDOFF, ARMED...).
    level_ready_i  = 1'b1;
    above_thresh_i = 1'b1;
    level_i        = 16'd100;
    for (int i = 0; i < 600; i++) step();
    level_ready_i  = 1'b0;
    above_thresh_i = 1'b0;
    checks++; if (trig_count_o !== 16'd300) begin errors++; $display("FAIL count_300 got %0d want 300", trig_count_o); end
    checks++; if (s_trig_count !== 8'd255) begin errors++; $display("FAIL count_saturate got %0d want 255", s_trig_count); end
    checks++; if (s_peak !== 16'd100) begin errors++; $display("FAIL sat_peak got %0d want 100", s_peak); end
  endtask

  initial begin
    reset_i        = 1'b1;
    cmd_start_i    = 1'b0;
    cmd_stop_i     = 1'b0;
    clr_event_i    = 1'b0;
    cfg_warmup_i   = 16'd0;
    cfg_hold_i     = 8'd1;
    cfg_holdoff_i  = 16'd0;
    pcm_valid_i    = 1'b0;
    level_i        = 16'd0;
    above_thresh_i = 1'b0;
    level_ready_i  = 1'b0;
    test_reset();
    test_warmup();
    test_qualify();
    test_simultaneous();
    test_restart_and_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
